// File: rtl/qubit_readout_ctrl.sv
// Qubit readout/correction controller: integrates the engine's measurement
// bit over a 2^WINDOW_LOG2 window, majority-votes a result, offers it on a
// valid/ready port and optionally drives a fixed-length correction pulse.
module qubit_readout_ctrl #(
  parameter int unsigned WINDOW_LOG2    = 4,
  parameter int unsigned ONES_MIN       = 9,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter logic [15:0] PULSE_STRENGTH = 16'h0324
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 correct_en,
  input  logic                 measurement,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 result_bit,
  output logic [WINDOW_LOG2:0] ones_count,
  output logic [15:0]          rounds,
  output logic                 apply_pulse,
  output logic [15:0]          pulse_strength
);

  localparam int unsigned PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PCW-1:0]       PC_LAST    = PCW'(PULSE_CYCLES - 1);
  localparam logic [WINDOW_LOG2:0] ONES_MIN_V = (WINDOW_LOG2 + 1)'(ONES_MIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    REPORT  = 2'd2,
    CORRECT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [WINDOW_LOG2-1:0] scnt_q, scnt_d;
  logic [WINDOW_LOG2:0]   acc_q, acc_d;
  logic [PCW-1:0]         pcnt_q, pcnt_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   bit_q, bit_d;
  logic [WINDOW_LOG2:0]   ones_q, ones_d;
  logic [15:0]            rounds_q, rounds_d;
  logic                   apply_q, apply_d;
  logic [15:0]            strength_q, strength_d;

  logic                   handshake;
  logic [WINDOW_LOG2:0]   acc_sum;

  assign handshake = valid_q && result_ready;
  assign acc_sum   = acc_q + {{WINDOW_LOG2{1'b0}}, measurement};

  // Next-state and registered-output logic for the readout FSM.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    acc_d      = acc_q;
    pcnt_d     = pcnt_q;
    valid_d    = valid_q;
    bit_d      = bit_q;
    ones_d     = ones_q;
    rounds_d   = rounds_q;
    apply_d    = apply_q;
    strength_d = strength_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          scnt_d  = '0;
          acc_d   = '0;
        end
      end
      SAMPLE: begin
        acc_d  = acc_sum;
        scnt_d = scnt_q + WINDOW_LOG2'(1);
        // Counter wrapping to zero marks the final sample of the window.
        if (scnt_q == '1) begin
          state_d = REPORT;
          ones_d  = acc_sum;
          bit_d   = (acc_sum >= ONES_MIN_V);
          valid_d = 1'b1;
        end
      end
      REPORT: begin
        if (handshake) begin
          valid_d  = 1'b0;
          rounds_d = rounds_q + 16'd1;
          if (bit_q && correct_en) begin
            state_d    = CORRECT;
            apply_d    = 1'b1;
            strength_d = PULSE_STRENGTH;
            pcnt_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CORRECT: begin
        if (pcnt_q == PC_LAST) begin
          state_d    = IDLE;
          apply_d    = 1'b0;
          strength_d = '0;
        end else begin
          pcnt_d = pcnt_q + PCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scnt_q     <= '0;
      acc_q      <= '0;
      pcnt_q     <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      bit_q      <= 1'b0;
      ones_q     <= '0;
      rounds_q   <= '0;
      apply_q    <= 1'b0;
      strength_q <= '0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      acc_q      <= acc_d;
      pcnt_q     <= pcnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      bit_q      <= bit_d;
      ones_q     <= ones_d;
      rounds_q   <= rounds_d;
      apply_q    <= apply_d;
      strength_q <= strength_d;
    end
  end

  assign busy           = busy_q;
  assign result_valid   = valid_q;
  assign result_bit     = bit_q;
  assign ones_count     = ones_q;
  assign rounds         = rounds_q;
  assign apply_pulse    = apply_q;
  assign pulse_strength = strength_q;

endmodule

// File: tb/tb_qubit_readout_ctrl.sv
// Bench for qubit_readout_ctrl: directed rounds push expected results into a
// scoreboard queue; a negedge monitor pops on each handshake and checks the
// result, the rounds counter and the correction pulse that follows.
module tb_qubit_readout_ctrl;

  localparam int unsigned WL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        correct_en = 1'b0;
  logic        measurement = 1'b0;
  logic        result_ready = 1'b0;
  logic        busy, result_valid, result_bit, apply_pulse;
  logic [WL:0] ones_count;
  logic [15:0] rounds, pulse_strength;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        bit_v;
    logic [WL:0] ones;
    logic [15:0] rnd;
    int          pulses;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_rounds = 16'd0;

  always #5 clk = ~clk;

  qubit_readout_ctrl #(
    .WINDOW_LOG2   (WL),
    .ONES_MIN      (9),
    .PULSE_CYCLES  (4),
    .PULSE_STRENGTH(16'h0324)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .correct_en    (correct_en),
    .measurement   (measurement),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_bit    (result_bit),
    .ones_count    (ones_count),
    .rounds        (rounds),
    .apply_pulse   (apply_pulse),
    .pulse_strength(pulse_strength)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},     32'(busy),           32'd0);
    chk({tag, " valid"},    32'(result_valid),   32'd0);
    chk({tag, " bit"},      32'(result_bit),     32'd0);
    chk({tag, " ones"},     32'(ones_count),     32'd0);
    chk({tag, " rounds"},   32'(rounds),         32'd0);
    chk({tag, " apply"},    32'(apply_pulse),    32'd0);
    chk({tag, " strength"}, 32'(pulse_strength), 32'd0);
  endtask

  // Mid-cycle asynchronous reset; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero({tag, " async_rst"});
    q.delete();
    exp_rounds = 16'd0;
    start = 1'b0;
    measurement = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // rst_mode: 0 none, 1 reset after 5 samples, 2 reset in 2nd pulse cycle.
  task automatic run_round(input string tag, input logic [15:0] pat, input logic ce,
                           input logic rdy, input int stall, input int rst_mode);
    int   ones;
    int   n;
    exp_t e;
    ones = 0;
    for (int i = 0; i < 16; i++) ones += int'(pat[i]);
    e.ones   = ones[WL:0];
    e.bit_v  = (ones >= 9);
    e.rnd    = exp_rounds + 16'd1;
    e.pulses = (e.bit_v && ce) ? 4 : 0;
    if (rst_mode != 1) begin
      q.push_back(e);
      exp_rounds = e.rnd;
    end
    start = 1'b1;
    correct_en = ce;
    result_ready = rdy;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_rise"}, 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (rst_mode == 1 && i == 5) begin
        do_reset(tag);
        return;
      end
      measurement = pat[i];
      if (i == 15) chk({tag, " valid_early"}, 32'(result_valid), 32'd0);
      @(posedge clk); #1;
    end
    measurement = 1'b0;
    chk({tag, " valid_latency"}, 32'(result_valid), 32'd1);
    chk({tag, " ones_at_valid"}, 32'(ones_count), 32'(e.ones));
    chk({tag, " bit_at_valid"}, 32'(result_bit), 32'(e.bit_v));
    if (stall > 0) begin
      start = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        chk({tag, " stall_valid"}, 32'(result_valid), 32'd1);
        chk({tag, " stall_ones"}, 32'(ones_count), 32'(e.ones));
        chk({tag, " stall_bit"}, 32'(result_bit), 32'(e.bit_v));
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (rst_mode == 2) begin
      n = 0;
      while (!apply_pulse && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk({tag, " pulse_seen"}, 32'(apply_pulse), 32'd1);
      @(posedge clk);
      do_reset(tag);
      return;
    end
    n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from DUT updates.
  int   pend = 0;
  int   track = 0;
  int   pcnt = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      track = 0;
    end else begin
      if (pend != 0) begin
        pend = 0;
        chk("hs rounds", 32'(rounds), 32'(cur.rnd));
        chk("hs valid_fall", 32'(result_valid), 32'd0);
        track = 1;
        pcnt = 0;
      end
      if (track != 0) begin
        if (apply_pulse) begin
          pcnt++;
          chk("pulse strength", 32'(pulse_strength), 32'h0324);
          if (pcnt > 32) begin
            chk("pulse bounded", 32'(pcnt), 32'(cur.pulses));
            track = 0;
          end
        end else begin
          chk("pulse_len", 32'(pcnt), 32'(cur.pulses));
          chk("busy after round", 32'(busy), 32'd0);
          chk("strength idle", 32'(pulse_strength), 32'd0);
          track = 0;
        end
      end
      if (result_valid && result_ready) begin
        chk("hs expected", 32'(q.size()), 32'd1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          chk("hs bit", 32'(result_bit), 32'(cur.bit_v));
          chk("hs ones", 32'(ones_count), 32'(cur.ones));
          pend = 1;
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_round("all0",     16'h0000, 1'b1, 1'b1, 0, 0);
    run_round("nine",     16'h01FF, 1'b0, 1'b1, 0, 0);
    run_round("eight",    16'h00FF, 1'b0, 1'b1, 0, 0);
    run_round("all1_ce",  16'hFFFF, 1'b1, 1'b1, 0, 0);
    run_round("all1_noc", 16'hFFFF, 1'b0, 1'b1, 0, 0);
    run_round("bp",       16'hFF0F, 1'b0, 1'b0, 10, 0);
    run_round("alt",      16'hAAAA, 1'b1, 1'b1, 0, 0);
    run_round("late9",    16'hFF80, 1'b1, 1'b1, 0, 0);

    run_round("rst_smp",  16'hFFFF, 1'b1, 1'b1, 0, 1);
    run_round("after_r1", 16'h0001, 1'b0, 1'b1, 0, 0);
    run_round("rst_pls",  16'hFFFF, 1'b1, 1'b1, 0, 2);
    run_round("after_r2", 16'h7FFF, 1'b1, 1'b1, 0, 0);

    @(posedge clk); #1;
    force dut.rounds_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.rounds_q;
    chk("wrap preload", 32'(rounds), 32'h0000FFFF);
    exp_rounds = 16'hFFFF;
    run_round("wrap", 16'h0000, 1'b0, 1'b1, 0, 0);

    repeat (3) @(posedge clk);
    #1 chk("queue drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
